// File: rtl/dct_row_stream_packer.sv
// Buffers 8x16b DCT result rows in a small FIFO and serialises each row into two
// 64-bit stream beats (LOW = elements 0..3, HIGH = elements 4..7) with t_last framing.
`timescale 1ns/1ps
module dct_row_stream_packer #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter bit          LAST_PER_BLOCK = 1'b0,
  parameter int unsigned DEST_W         = 1
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              clr_i,
  input  logic              row_valid_i,
  output logic              row_ready_o,
  input  logic [7:0][15:0]  row_data_i,
  input  logic              row_last_i,
  output logic              out_t_valid_o,
  output logic [63:0]       out_t_data_o,
  output logic [7:0]        out_t_keep_o,
  output logic [7:0]        out_t_strb_o,
  output logic              out_t_last_o,
  output logic [DEST_W-1:0] out_t_dest_o,
  input  logic              out_t_ready_i,
  output logic              busy_o,
  output logic              align_err_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic            last;
    logic [7:0][15:0] elem;
  } row_t;

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH} state_t;

  row_t             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  state_t           state_q;
  logic             t_valid_q, t_last_q, align_err_q;
  logic [63:0]      t_data_q;
  logic [3:0]       beat_cnt_q;
  logic [2:0]       push_pos_q;

  logic push, pop;
  row_t head, nxt;

  assign row_ready_o = (count_q < CNT_W'(FIFO_DEPTH));
  assign push        = row_valid_i && row_ready_o;
  assign pop         = (state_q == S_HIGH) && out_t_ready_i;
  assign count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
  assign head        = mem_q[rd_ptr_q];
  assign nxt         = mem_q[rd_ptr_q + 1'b1];

  assign out_t_valid_o = t_valid_q;
  assign out_t_data_o  = t_data_q;
  assign out_t_last_o  = t_last_q;
  assign out_t_keep_o  = {8{t_valid_q}};
  assign out_t_strb_o  = {8{t_valid_q}};
  assign out_t_dest_o  = '0;
  assign busy_o        = (count_q != '0) || t_valid_q;
  assign align_err_o   = align_err_q;

  // Row storage: data-only, no reset needed since occupancy is tracked by count_q.
  always_ff @(posedge aclk) begin
    if (push && !clr_i) mem_q[wr_ptr_q] <= {row_last_i, row_data_i};
  end

  // FIFO pointers, output beat FSM, stream counters and alignment check.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= S_IDLE;
      t_valid_q   <= 1'b0;
      t_last_q    <= 1'b0;
      t_data_q    <= '0;
      beat_cnt_q  <= '0;
      push_pos_q  <= '0;
      align_err_q <= 1'b0;
    end else if (clr_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= S_IDLE;
      t_valid_q   <= 1'b0;
      t_last_q    <= 1'b0;
      t_data_q    <= '0;
      beat_cnt_q  <= '0;
      push_pos_q  <= '0;
      align_err_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;

      unique case (state_q)
        S_IDLE: begin
          // An empty FIFO forwards a freshly accepted row straight to the LOW beat.
          if (count_q != '0) begin
            t_data_q  <= head.elem[3:0];
            t_last_q  <= 1'b0;
            t_valid_q <= 1'b1;
            state_q   <= S_LOW;
          end else if (push) begin
            t_data_q  <= row_data_i[3:0];
            t_last_q  <= 1'b0;
            t_valid_q <= 1'b1;
            state_q   <= S_LOW;
          end
        end
        S_LOW: begin
          if (out_t_ready_i) begin
            t_data_q   <= head.elem[7:4];
            t_last_q   <= head.last || (LAST_PER_BLOCK && (beat_cnt_q[3:1] == 3'd7));
            beat_cnt_q <= beat_cnt_q + 4'd1;
            state_q    <= S_HIGH;
          end
        end
        S_HIGH: begin
          if (out_t_ready_i) begin
            rd_ptr_q   <= rd_ptr_q + 1'b1;
            beat_cnt_q <= head.last ? 4'd0 : beat_cnt_q + 4'd1;
            if (count_q > CNT_W'(1)) begin
              t_data_q <= nxt.elem[3:0];
              t_last_q <= 1'b0;
              state_q  <= S_LOW;
            end else begin
              t_valid_q <= 1'b0;
              t_last_q  <= 1'b0;
              t_data_q  <= '0;
              state_q   <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (push) begin
        align_err_q <= row_last_i && (push_pos_q != 3'd7);
        push_pos_q  <= row_last_i ? 3'd0 : push_pos_q + 3'd1;
      end else begin
        align_err_q <= 1'b0;
      end
    end
  end

endmodule
